// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   - arbiter state codes (2-bit)
//   - requester identifiers used for round-robin bookkeeping
//   - default block size and counter width
package mem_arbiter_pkg;

   localparam int unsigned DEF_BLOCK_WORDS = 8;
   localparam int unsigned CNT_W           = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWrite = 2'd1,
      StFillI = 2'd2,
      StFillD = 2'd3
   } arb_state_e;

   typedef enum logic {
      ReqI = 1'b0,
      ReqD = 1'b1
   } req_id_e;

endpackage

// File: rtl/arb_beat_counter.sv
// Saturating up-counter used for the arbiter's issue and beat counts.
//   clk   : system clock
//   clr   : synchronous clear (wins over en)
//   en    : count enable; ignored once the count reaches MAX
//   count : current count
module arb_beat_counter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX);

   logic [CNT_W-1:0] count_q, count_d;
   logic [3:0]       p, c, sum;
   logic [2:0]       g;
   logic             sat;

   // Carry-lookahead increment: count + 1.
   always_comb begin
      p    = count_q ^ 4'b0001;
      g    = count_q[2:0] & 3'b001;
      c[0] = 1'b0;
      c[1] = g[0];
      c[2] = g[1] | (p[1] & g[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
      sum  = p ^ c;
   end

   assign sat = (count_q == MaxVal);

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && !sat) begin
         count_d = sum;
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one pipelined unified memory between the I-cache fill FSM,
// the D-cache fill FSM and D-cache write-through stores.
//   clk, rst            : clock, synchronous active-high reset
//   i_miss, i_addr      : I fill request and its current memory address
//   d_miss, d_addr      : D fill request and its current memory address
//   d_wr_req/addr/data  : single-cycle store request
//   mem_data_valid      : read data valid from memory
//   mem_enable/wr/addr/data_in : memory command outputs
//   i_grant, d_grant    : fill ownership
//   i_data_valid, d_data_valid : valid beats routed to the owner only
//   i_force_reset, d_force_reset : hold non-owning fill FSMs in reset
//   d_wr_ack            : store performed this cycle
//   arb_busy            : arbiter not idle
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_miss,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_miss,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_wr_req,
   input  logic [ADDR_W-1:0] d_wr_addr,
   input  logic [DATA_W-1:0] d_wr_data,
   input  logic              mem_data_valid,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              i_grant,
   output logic              d_grant,
   output logic              i_data_valid,
   output logic              d_data_valid,
   output logic              i_force_reset,
   output logic              d_force_reset,
   output logic              d_wr_ack,
   output logic              arb_busy
);

   localparam logic [CNT_W-1:0] BlockCnt = CNT_W'(BLOCK_WORDS);
   localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BLOCK_WORDS - 1);

   arb_state_e       state_q, state_d;
   req_id_e          last_q, last_d;
   logic [CNT_W-1:0] issue_cnt, beat_cnt;
   logic             filling, next_filling, last_beat, issue_win, cnt_clr;
   logic [ADDR_W-1:0] owner_addr;

   assign filling      = (state_q == StFillI) || (state_q == StFillD);
   assign next_filling = (state_d == StFillI) || (state_d == StFillD);
   assign owner_addr   = (state_q == StFillD) ? d_addr : i_addr;
   assign last_beat    = filling && mem_data_valid && (beat_cnt == LastBeat);
   // Reads go out on the cycles after the grant cycle: issue_cnt 1..BLOCK_WORDS.
   assign issue_win    = (issue_cnt >= 4'd1) && (issue_cnt <= BlockCnt);
   // Counters are zero whenever the arbiter is (or is about to be) outside a fill.
   assign cnt_clr      = rst || !next_filling;

   // The issue counter runs one past the block so the read window closes
   // after exactly BLOCK_WORDS cycles while the beats are still returning.
   arb_beat_counter #(
      .MAX (BLOCK_WORDS + 1)
   ) u_issue_cnt (
      .clk   (clk),
      .clr   (cnt_clr),
      .en    (filling),
      .count (issue_cnt)
   );

   arb_beat_counter #(
      .MAX (BLOCK_WORDS)
   ) u_beat_cnt (
      .clk   (clk),
      .clr   (cnt_clr),
      .en    (filling && mem_data_valid),
      .count (beat_cnt)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (d_wr_req) begin
               state_d = StWrite;
            end else if (i_miss && d_miss) begin
               state_d = (last_q == ReqI) ? StFillD : StFillI;
            end else if (i_miss) begin
               state_d = StFillI;
            end else if (d_miss) begin
               state_d = StFillD;
            end
         end
         StWrite: state_d = StIdle;
         StFillI, StFillD: begin
            if (last_beat) begin
               state_d = StIdle;
               last_d  = (state_q == StFillD) ? ReqD : ReqI;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         last_q  <= ReqI;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      mem_enable  = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_data_in = '0;
      d_wr_ack    = 1'b0;
      if (state_q == StWrite) begin
         mem_enable  = 1'b1;
         mem_wr      = 1'b1;
         mem_addr    = d_wr_addr;
         mem_data_in = d_wr_data;
         d_wr_ack    = 1'b1;
      end else if (filling && issue_win) begin
         mem_enable = 1'b1;
         mem_addr   = owner_addr;
      end
   end

   assign i_grant       = (state_q == StFillI);
   assign d_grant       = (state_q == StFillD);
   assign i_data_valid  = i_grant && mem_data_valid;
   assign d_data_valid  = d_grant && mem_data_valid;
   assign i_force_reset = !i_grant;
   assign d_force_reset = !d_grant;
   assign arb_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level ownership model.
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int BW = 8;
   localparam int O_NONE = 0, O_WR = 1, O_I = 2, O_D = 3;

   logic          clk = 1'b0;
   logic          rst, i_miss, d_miss, d_wr_req, stray;
   logic [AW-1:0] i_addr, d_addr, d_wr_addr;
   logic [DW-1:0] d_wr_data;
   logic          mem_data_valid;
   logic          mem_enable, mem_wr, i_grant, d_grant, i_data_valid, d_data_valid;
   logic          i_force_reset, d_force_reset, d_wr_ack, arb_busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   mem_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .BLOCK_WORDS (BW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_miss         (i_miss),
      .i_addr         (i_addr),
      .d_miss         (d_miss),
      .d_addr         (d_addr),
      .d_wr_req       (d_wr_req),
      .d_wr_addr      (d_wr_addr),
      .d_wr_data      (d_wr_data),
      .mem_data_valid (mem_data_valid),
      .mem_enable     (mem_enable),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_data_in    (mem_data_in),
      .i_grant        (i_grant),
      .d_grant        (d_grant),
      .i_data_valid   (i_data_valid),
      .d_data_valid   (d_data_valid),
      .i_force_reset  (i_force_reset),
      .d_force_reset  (d_force_reset),
      .d_wr_ack       (d_wr_ack),
      .arb_busy       (arb_busy)
   );

   always #5 clk = ~clk;

   // 4-cycle pipelined memory: a read issued in cycle t returns valid in t+4.
   logic [3:0] pipe = 4'b0;
   always @(posedge clk) pipe <= {pipe[2:0], mem_enable & ~mem_wr};
   assign mem_data_valid = pipe[3] | stray;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Ownership model: who holds memory, cycles since grant, beats received.
   int m_owner = O_NONE, m_age = 0, m_beats = 0, m_last = 0;
   always @(posedge clk) begin
      if (rst) begin
         m_owner <= O_NONE; m_age <= 0; m_beats <= 0; m_last <= 0;
      end else if (m_owner == O_NONE) begin
         m_age <= 0; m_beats <= 0;
         if (d_wr_req) m_owner <= O_WR;
         else if (i_miss && d_miss) m_owner <= (m_last == 0) ? O_D : O_I;
         else if (i_miss) m_owner <= O_I;
         else if (d_miss) m_owner <= O_D;
      end else if (m_owner == O_WR) begin
         m_owner <= O_NONE;
      end else if (mem_data_valid && m_beats == BW - 1) begin
         m_owner <= O_NONE;
         m_last  <= (m_owner == O_D) ? 1 : 0;
      end else begin
         m_age   <= m_age + 1;
         m_beats <= m_beats + (mem_data_valid ? 1 : 0);
      end
   end

   logic          e_fill, e_en;
   logic [9:0]    e_ctrl, a_ctrl;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data;
   always @(negedge clk) begin
      if (chk_en) begin
         e_fill = (m_owner == O_I) || (m_owner == O_D);
         e_en   = (m_owner == O_WR) || (e_fill && m_age >= 1 && m_age <= BW);
         e_ctrl = {e_en, m_owner == O_WR, m_owner == O_I, m_owner == O_D,
                   (m_owner == O_I) && mem_data_valid, (m_owner == O_D) && mem_data_valid,
                   m_owner != O_I, m_owner != O_D, m_owner == O_WR, m_owner != O_NONE};
         e_addr = (m_owner == O_WR) ? d_wr_addr :
                  (e_en ? ((m_owner == O_D) ? d_addr : i_addr) : '0);
         e_data = (m_owner == O_WR) ? d_wr_data : '0;
         a_ctrl = {mem_enable, mem_wr, i_grant, d_grant, i_data_valid, d_data_valid,
                   i_force_reset, d_force_reset, d_wr_ack, arb_busy};
         check("ctrl", 32'(a_ctrl), 32'(e_ctrl));
         check("mem_addr", 32'(mem_addr), 32'(e_addr));
         check("mem_data_in", 32'(mem_data_in), 32'(e_data));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   // Runs a fill until BLOCK_WORDS beats reach the owner, then drops its miss.
   task automatic fill_run(input bit is_d, output int beats);
      beats = 0;
      for (int n = 0; n < 40 && beats < BW; n++) begin
         look();
         if (is_d ? d_data_valid : i_data_valid) beats++;
         cyc();
      end
      if (is_d) d_miss = 1'b0;
      else i_miss = 1'b0;
   endtask

   int  ec, bc, oc, sc, beats;
   bit  en_seen;
   logic [AW-1:0] last_a;

   initial begin
      rst = 1'b1; i_miss = 0; d_miss = 0; d_wr_req = 0; stray = 0;
      i_addr = '0; d_addr = '0; d_wr_addr = '0; d_wr_data = '0;
      cyc();
      chk_en = 1'b1;
      cyc();
      look();
      check("rst_i_force", 32'(i_force_reset), 32'd1);
      check("rst_d_force", 32'(d_force_reset), 32'd1);
      check("rst_busy", 32'(arb_busy), 32'd0);
      check("rst_mem_en", 32'(mem_enable), 32'd0);

      // Single I fill with an address sweep.
      cyc();
      rst = 1'b0; i_miss = 1'b1; i_addr = 16'h1230;
      ec = 0; bc = 0; oc = 0; last_a = '0;
      for (int n = 0; n < 40 && bc < BW; n++) begin
         look();
         en_seen = mem_enable;
         if (en_seen) begin ec++; last_a = mem_addr; end
         if (i_data_valid) bc++;
         if (d_data_valid) oc++;
         cyc();
         if (en_seen) i_addr = i_addr + 16'd2;
      end
      i_miss = 1'b0;
      look();
      check("idle_after_fill", 32'(arb_busy), 32'd0);
      check("read_cycles", ec, 8);
      check("i_beats", bc, 8);
      check("d_beats_none", oc, 0);
      check("last_read_addr", 32'(last_a), 32'h123E);

      // Simultaneous misses: D first, then I, then D again.
      cyc();
      i_miss = 1'b1; d_miss = 1'b1;
      cyc(); look();
      check("tie1_d_first", 32'(d_grant), 32'd1);
      fill_run(1'b1, beats);
      cyc(); look();
      check("tie1_i_second", 32'(i_grant), 32'd1);
      fill_run(1'b0, beats);
      i_miss = 1'b1; d_miss = 1'b1;
      cyc(); look();
      check("tie2_d_again", 32'(d_grant), 32'd1);
      fill_run(1'b1, beats);
      fill_run(1'b0, beats);

      // Store arriving during an I fill waits for IDLE.
      i_miss = 1'b1;
      cyc();
      d_wr_req = 1'b1; d_wr_addr = 16'h4000; d_wr_data = 16'hBEEF;
      fill_run(1'b0, beats);
      check("fill_under_wr", beats, 8);
      look();
      check("wr_wait_idle", 32'(arb_busy), 32'd0);
      cyc(); look();
      check("wr_strobe", 32'(mem_wr), 32'd1);
      check("wr_addr", 32'(mem_addr), 32'h4000);
      check("wr_data", 32'(mem_data_in), 32'hBEEF);
      check("wr_ack", 32'(d_wr_ack), 32'd1);
      cyc();
      d_wr_req = 1'b0;

      // Store and D miss together: store first.
      d_wr_req = 1'b1; d_wr_addr = 16'h5000; d_wr_data = 16'h1234; d_miss = 1'b1;
      cyc();
      d_wr_req = 1'b0;
      look();
      check("wr_before_fill", 32'(d_wr_ack), 32'd1);
      cyc(); look();
      check("gap_idle", 32'(arb_busy), 32'd0);
      cyc(); look();
      check("fill_d_after_wr", 32'(d_grant), 32'd1);
      fill_run(1'b1, beats);

      // Reset after the third beat of a fill.
      i_miss = 1'b1; bc = 0;
      for (int n = 0; n < 40 && bc < 3; n++) begin
         look();
         if (i_data_valid) bc++;
         cyc();
      end
      rst = 1'b1; i_miss = 1'b0;
      cyc();
      rst = 1'b0;
      look();
      check("mid_rst_i_force", 32'(i_force_reset), 32'd1);
      check("mid_rst_d_force", 32'(d_force_reset), 32'd1);
      check("mid_rst_busy", 32'(arb_busy), 32'd0);
      sc = 0;
      for (int n = 0; n < 8; n++) begin
         look();
         if (i_data_valid || d_data_valid) sc++;
         cyc();
      end
      check("dropped_returns", sc, 0);
      i_miss = 1'b1;
      fill_run(1'b0, beats);
      check("fresh_fill", beats, 8);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         cyc();
         rst       = ($urandom_range(0, 299) == 0);
         i_miss    = ($urandom_range(0, 2) == 0);
         d_miss    = ($urandom_range(0, 2) == 0);
         d_wr_req  = ($urandom_range(0, 7) == 0);
         stray     = ($urandom_range(0, 15) == 0);
         i_addr    = 16'($urandom);
         d_addr    = 16'($urandom);
         d_wr_addr = 16'($urandom);
         d_wr_data = 16'($urandom);
      end
      cyc();
      rst = 1'b0; i_miss = 0; d_miss = 0; d_wr_req = 0; stray = 0;
      for (int n = 0; n < 20; n++) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 4-cycle pipelined unified memory between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores.
- Grants the memory to one requester at a time. A grant lasts either one full 8-word block fill or one single-cycle write.
- Muxes address and data to memory and routes returning read-valid beats back to the current owner only.
- Holds each non-owning fill FSM in reset through its arb_force_reset input.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- BLOCK_WORDS, 8, words per cache block (reads issued and valid beats expected per fill).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_miss  in  1  I-cache miss pending (I fill FSM miss_detected).
- i_addr  in  ADDR_W  I fill FSM memory_address.
- d_miss  in  1  D-cache miss pending.
- d_addr  in  ADDR_W  D fill FSM memory_address.
- d_wr_req  in  1  D-cache write-through store request.
- d_wr_addr  in  ADDR_W  store address.
- d_wr_data  in  DATA_W  store data.
- mem_data_valid  in  1  memory read-data valid.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  memory write strobe (1 = write).
- mem_addr  out  ADDR_W  memory address.
- mem_data_in  out  DATA_W  memory write data.
- i_grant  out  1  I fill owns memory.
- d_grant  out  1  D fill owns memory.
- i_data_valid  out  1  mem_data_valid gated to the I fill.
- d_data_valid  out  1  mem_data_valid gated to the D fill.
- i_force_reset  out  1  drives the I fill FSM arb_force_reset.
- d_force_reset  out  1  drives the D fill FSM arb_force_reset.
- d_wr_ack  out  1  store accepted this cycle.
- arb_busy  out  1  state != IDLE.

Behaviour:
- Interface:
  - Single clock clk.
  - rst is synchronous and active-high.
  - All state is updated on the rising clk edge.
- States: IDLE, WRITE, FILL_I, FILL_D (2-bit register).
- Reset:
  - state = IDLE, issue_cnt = 0, beat_cnt = 0, last_served = I.
  - Outputs: mem_enable = 0, mem_wr = 0, mem_addr = 0, mem_data_in = 0, both grants = 0, both data_valids = 0, d_wr_ack = 0, arb_busy = 0, i_force_reset = 1, d_force_reset = 1.
- Force reset: i_force_reset = ~i_grant and d_force_reset = ~d_grant, decoded from the state register (not from inputs).
- IDLE arbitration (combinational, taken at the edge):
  - d_wr_req has top priority -> WRITE.
  - Else a single miss goes to its FILL state.
  - If both misses are pending, grant the requester not equal to last_served (round-robin). Because last_served resets to I, D wins the first tie.
  - No request -> stay IDLE.
- WRITE (exactly 1 cycle):
  - mem_enable = 1, mem_wr = 1, mem_addr = d_wr_addr, mem_data_in = d_wr_data, d_wr_ack = 1.
  - Next state is IDLE.
- FILL_x, entered at cycle G:
  - grant_x = 1 from cycle G, which releases that FSM's force reset.
  - issue_cnt increments each cycle from G.
  - mem_enable = 1 (mem_wr = 0) while 1 <= issue_cnt <= BLOCK_WORDS, i.e. cycles G+1..G+8.
  - During that window mem_addr = owner addr (base+0 .. base+14).
  - x_data_valid = mem_data_valid. The other requester's data_valid stays 0.
  - beat_cnt counts valid beats. The cycle E carrying beat BLOCK_WORDS moves state to IDLE at E+1.
  - Set last_served = x when the fill ends.
  - issue_cnt and beat_cnt clear on every entry to IDLE.
- A d_wr_req or miss that arrives during a grant waits. It is evaluated in IDLE, so there is always at least one IDLE cycle between grants.
- mem_data_valid outside FILL states is ignored: both data_valids = 0 and beat_cnt is unchanged.
- An owner's miss deasserting mid-fill does not end the grant. The grant ends only on the final beat.
- rst mid-fill or mid-write:
  - Go to IDLE immediately at the edge.
  - Both force_resets assert the next cycle.
  - In-flight memory returns are dropped.
- Counters are 4 bits wide and must not wrap. Saturate at BLOCK_WORDS.
- mem_addr is 0 when mem_enable = 0.

Decomposition:
- Shared header (mem_arb_defs):
  - State codes IDLE = 0, WRITE = 1, FILL_I = 2, FILL_D = 3.
  - BLOCK_WORDS.
  - Requester IDs I = 0, D = 1.
- Sub-module arb_beat_counter: 4-bit saturating counter with synchronous clear and enable, built from the existing Register_4bit and CLA_4b.
- Instantiate it twice: once for issue_cnt, once for beat_cnt.

Test Plan:
- rst = 1 for 2 cycles -> all outputs 0 except i_force_reset = d_force_reset = 1; arb_busy = 0.
- i_miss = 1, i_addr sweeping 0x1230..0x123E -> i_grant = 1 at G; mem_enable = 1 for exactly 8 cycles (G+1..G+8) with mem_addr = i_addr; 8 valid beats appear only on i_data_valid; IDLE one cycle after the 8th beat.
- i_miss and d_miss asserted together after reset -> D fill first, then I fill; on a second simultaneous pair, D is granted again because I was served last.
- d_wr_req with addr 0x4000, data 0xBEEF during an I fill -> held until IDLE; then one cycle with mem_wr = 1, mem_addr = 0x4000, mem_data_in = 0xBEEF, d_wr_ack = 1.
- d_wr_req and d_miss in the same IDLE cycle -> WRITE first, then FILL_D on the following IDLE.
- rst pulsed after the 3rd valid beat of a fill -> IDLE next cycle; later mem_data_valid pulses give no data_valid output; a new miss gets a fresh 8-beat fill.
